// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the 26-bit core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with both memories and traps on faults.
module ctrl_seq #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             flag_z,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             pc_inc,
  output logic             pc_load_rel,
  output logic             pc_load_abs,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // The wait that ends on this counter value is the TMO_MAX-th cycle without ack.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_t           state_r, next_state_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [1:0]       err_code_r, next_err_s;
  logic [CNT_W-1:0] retired_r;
  logic             tmo_limit_s, pc_upd_s, unused_s;
  logic             imem_req_s, ir_load_s, dmem_req_s, dmem_we_s, alu_src_imm_s;
  logic             reg_we_s, wb_sel_s, pc_inc_s, pc_load_rel_s, pc_load_abs_s;

  assign tmo_limit_s = (tmo_cnt_r == TMO_LAST);
  assign unused_s    = ^opcode[1:0];

  // Next-state and strobe decode from the registered state
  always_comb begin
    next_state_s  = state_r;
    next_err_s    = err_code_r;
    imem_req_s    = 1'b0;
    ir_load_s     = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    alu_src_imm_s = 1'b0;
    reg_we_s      = 1'b0;
    wb_sel_s      = 1'b0;
    pc_inc_s      = 1'b0;
    pc_load_rel_s = 1'b0;
    pc_load_abs_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_load_s    = 1'b1;
          next_state_s = S_DECODE;
        end else if (tmo_limit_s) begin
          next_state_s = S_TRAP;
          next_err_s   = 2'b10;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (opcode[5:3] == 3'b101) begin
          next_state_s = S_TRAP;
          next_err_s   = 2'b01;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode[5:4])
          2'b00, 2'b01: begin
            alu_src_imm_s = opcode[3];
            if (opcode == 6'b000000) begin
              pc_inc_s     = 1'b1;
              next_state_s = S_FETCH;
            end else begin
              next_state_s = S_WB;
            end
          end
          2'b10: next_state_s = S_MEM;
          2'b11: begin
            if (opcode[3]) begin
              pc_load_abs_s = 1'b1;
            end else if (flag_z) begin
              pc_load_rel_s = 1'b1;
            end else begin
              pc_inc_s = 1'b1;
            end
            next_state_s = S_FETCH;
          end
          default: begin
            next_state_s = S_TRAP;
            next_err_s   = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = opcode[2];
        if (dmem_ack) begin
          if (opcode[2]) begin
            pc_inc_s     = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_WB;
          end
        end else if (tmo_limit_s) begin
          next_state_s = S_TRAP;
          next_err_s   = 2'b10;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB: begin
        reg_we_s     = 1'b1;
        wb_sel_s     = (opcode[5:4] == 2'b10);
        pc_inc_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_TRAP:  next_state_s = S_TRAP;
      default: next_state_s = S_TRAP;
    endcase
  end

  // A reset cycle must not let a half-finished instruction write back or move the PC.
  assign imem_req    = imem_req_s & ~rst;
  assign ir_load     = ir_load_s & ~rst;
  assign dmem_req    = dmem_req_s & ~rst;
  assign dmem_we     = dmem_we_s & ~rst;
  assign alu_src_imm = alu_src_imm_s & ~rst;
  assign reg_we      = reg_we_s & ~rst;
  assign wb_sel      = wb_sel_s & ~rst;
  assign pc_inc      = pc_inc_s & ~rst;
  assign pc_load_rel = pc_load_rel_s & ~rst;
  assign pc_load_abs = pc_load_abs_s & ~rst;
  assign pc_upd_s    = pc_inc | pc_load_rel | pc_load_abs;

  assign busy     = (state_r != S_TRAP);
  assign trap     = (state_r == S_TRAP);
  assign err_code = err_code_r;
  assign retired  = retired_r;

  // State and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      err_code_r <= 2'b00;
    end else begin
      state_r    <= next_state_s;
      err_code_r <= next_err_s;
    end
  end

  // Memory-wait counter: restarts on every state change, counts unacknowledged waits
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == S_FETCH && !imem_ack) || (state_r == S_MEM && !dmem_ack)) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Retired-instruction counter, one per PC update pulse, free-running wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= '0;
    end else if (pc_upd_s) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

endmodule
